// File: rtl/mdu_iter_if.sv
// Handshake and operand/result bundle between the EX stage and the
// iterative multiply/divide unit.
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             flush_i;
    logic             except_i;
    logic             busy_o;
    logic             stall_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, a_i, b_i, flush_i, except_i,
        input  busy_o, stall_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, flush_i, except_i,
        output busy_o, stall_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative signed/unsigned MULT/DIV unit, one bit per cycle.
// Works on magnitudes and applies sign correction in the FIX state.
module mdu_iter #(
    parameter int WIDTH  = 32,
    parameter bit DIV_EN = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    mdu_iter_if.slave  bus
);
    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [1:0]     S_IDLE   = 2'd0;
    localparam logic [1:0]     S_RUN    = 2'd1;
    localparam logic [1:0]     S_FIX    = 2'd2;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    function automatic logic [WIDTH-1:0] cneg(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               sign_a_s, sign_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH:0]     div_rem_s, div_diff_s;
    logic               div_ge_s;
    logic [2*WIDTH-1:0] div_next_s;
    logic [2*WIDTH-1:0] prod_s;

    assign sign_a_s = ~bus.op_i[0] & bus.a_i[WIDTH-1];
    assign sign_b_s = ~bus.op_i[0] & bus.b_i[WIDTH-1];

    // acc holds {hi, lo}: shift-add keeps the multiplier in the low half,
    // restoring division keeps {remainder, dividend/quotient}.
    assign mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign mul_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};
    assign div_rem_s  = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff_s = div_rem_s - {1'b0, b_q};
    assign div_ge_s   = ~div_diff_s[WIDTH];
    assign div_next_s = {(div_ge_s ? div_diff_s[WIDTH-1:0] : div_rem_s[WIDTH-1:0]),
                         acc_q[WIDTH-2:0], div_ge_s};
    assign prod_s     = neg_res_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    op_d      = bus.op_i;
                    neg_res_d = sign_a_s ^ sign_b_s;
                    neg_rem_d = sign_a_s;
                    cnt_d     = '0;
                    a_d       = cneg(sign_a_s, bus.a_i);
                    b_d       = cneg(sign_b_s, bus.b_i);
                    dz_d      = 1'b0;
                    if (bus.op_i[1]) begin
                        acc_d = {{WIDTH{1'b0}}, cneg(sign_a_s, bus.a_i)};
                        if (!DIV_EN) begin
                            state_d = S_FIX;
                        end else if (bus.b_i == '0) begin
                            dz_d    = 1'b1;
                            a_d     = bus.a_i;
                            state_d = S_FIX;
                        end else begin
                            state_d = S_RUN;
                        end
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, cneg(sign_b_s, bus.b_i)};
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d = op_q[1] ? div_next_s : mul_next_s;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FIX: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (op_q[1]) begin
                    if (!DIV_EN) begin
                        hi_d = '0;
                        lo_d = '0;
                    end else if (dz_q) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = cneg(neg_rem_q, acc_q[2*WIDTH-1:WIDTH]);
                        lo_d = cneg(neg_res_q, acc_q[WIDTH-1:0]);
                    end
                end else begin
                    hi_d = prod_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Flush wins over everything, including a start and a pending result.
        if (bus.flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end else begin
            state_d = state_d;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= 2'b00;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy_o  = (state_q != S_IDLE);
    assign bus.stall_o = ((state_q != S_IDLE) | bus.start_i) & ~done_q & ~bus.except_i;
    assign bus.done_o  = done_q;
    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: a result table plus hand-written
// flush, reset, stall and back-to-back sequences.
module tb_mdu_iter;
    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t vecs[12];

    mdu_iter_if #(.WIDTH(32)) bus ();

    mdu_iter #(.WIDTH(32), .DIV_EN(1'b1)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // called at a negedge; returns at the negedge after the sampling edge
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.done_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 34};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 34};
        vecs[3]  = '{2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 2};
        vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34};
        vecs[5]  = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 34};
        vecs[6]  = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 34};
        vecs[7]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34};
        vecs[8]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 34};
        vecs[9]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 2};
        vecs[10] = '{2'b00, 32'h00000000, 32'hFFFFFFFB, 32'h00000000, 32'h00000000, 34};
        vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 34};

        bus.start_i  = 1'b0;
        bus.op_i     = 2'b00;
        bus.a_i      = 32'h0;
        bus.b_i      = 32'h0;
        bus.flush_i  = 1'b0;
        bus.except_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(bus.busy_o), 64'h0);
        chk("reset_done", 64'(bus.done_o), 64'h0);
        chk("reset_hilo", {bus.hi_o, bus.lo_o}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("vec%0d_hi", i), 64'(bus.hi_o), 64'(vecs[i].hi));
            chk($sformatf("vec%0d_lo", i), 64'(bus.lo_o), 64'(vecs[i].lo));
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), 64'(bus.done_o), 64'h0);
        end

        // stall behaviour and except masking (MULT -3*7)
        bus.start_i = 1'b1;
        bus.op_i    = 2'b00;
        bus.a_i     = 32'hFFFFFFFD;
        bus.b_i     = 32'h00000007;
        #1 chk("stall_on_start", 64'(bus.stall_o), 64'h1);
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("stall_busy", 64'(bus.stall_o), 64'h1);
        bus.except_i = 1'b1;
        #1 chk("stall_except", 64'(bus.stall_o), 64'h0);
        chk("busy_except", 64'(bus.busy_o), 64'h1);
        bus.except_i = 1'b0;
        #1 chk("stall_resume", 64'(bus.stall_o), 64'h1);
        wait_done(lat);
        chk("stall_seq_lat", 64'(lat), 64'd34);
        chk("stall_at_done", 64'(bus.stall_o), 64'h0);
        chk("stall_seq_res", {bus.hi_o, bus.lo_o}, 64'hFFFFFFFF_FFFFFFEB);

        // back-to-back start in the done cycle; start while busy is ignored
        start_op(2'b01, 32'h12345678, 32'h00000010);
        repeat (5) @(negedge clk);
        start_op(2'b11, 32'h00000007, 32'h00000000);
        wait_done(lat);
        chk("ignored_start_lat", 64'(lat), 64'd28);
        chk("ignored_start_res", {bus.hi_o, bus.lo_o}, 64'h00000001_23456780);

        // flush in RUN cycle 10, then restart one cycle later
        start_op(2'b00, 32'h00000003, 32'h00000005);
        repeat (9) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("flush_busy", 64'(bus.busy_o), 64'h0);
        chk("flush_done", 64'(bus.done_o), 64'h0);
        chk("flush_hold", {bus.hi_o, bus.lo_o}, 64'h00000001_23456780);
        @(negedge clk);
        start_op(2'b00, 32'h00000003, 32'h00000005);
        wait_done(lat);
        chk("after_flush_lat", 64'(lat), 64'd34);
        chk("after_flush_res", {bus.hi_o, bus.lo_o}, 64'h00000000_0000000F);
        @(negedge clk);

        // flush has priority over start in IDLE
        bus.flush_i = 1'b1;
        start_op(2'b01, 32'h00000002, 32'h00000002);
        bus.flush_i = 1'b0;
        chk("flush_vs_start", 64'(bus.busy_o), 64'h0);

        // asynchronous reset in the middle of RUN
        start_op(2'b01, 32'hFFFFFFFF, 32'h00000003);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(bus.busy_o), 64'h0);
        chk("rst_done", 64'(bus.done_o), 64'h0);
        chk("rst_hilo", {bus.hi_o, bus.lo_o}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_op(2'b11, 32'h00000064, 32'h00000007);
        wait_done(lat);
        chk("post_rst_lat", 64'(lat), 64'd34);
        chk("post_rst_res", {bus.hi_o, bus.lo_o}, 64'h00000002_0000000E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
